// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Latency: DW+1 cycles after start for a nonzero divisor, 2 cycles for a zero divisor.
// Backpressure: stall_req holds IF/ID/EX while a divide is in flight; it drops in DONE or on annul.
//
// Ports:
//   clk, rst             pipeline clock, async active-high reset
//   start, signed_div    EX holds a valid DIV (signed_div=1) or DIVU
//   opa, opb             dividend / divisor
//   annul                cancel any in-flight divide
//   stall_req            hold the earlier pipeline stages
//   result_valid         one-cycle pulse while quotient/remainder/div_zero are fresh
//   quotient, remainder  results for LO / HI, held until the next completed divide
//   div_zero             divisor was zero for the held result
module div_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_div,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    input  logic          annul,
    output logic          stall_req,
    output logic          result_valid,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = $clog2(DW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ZERO = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [DW-1:0] dvd;     // dividend magnitude, shifted out as quotient bits shift in
    logic [DW-1:0] dvs;     // divisor magnitude
    logic [DW-1:0] rem;     // partial remainder
    logic          sign_q;
    logic          sign_r;

    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [DW:0]   rem_sh;
    logic [DW+1:0] diff;
    logic          borrow;
    logic [DW-1:0] rem_nxt;
    logic [DW-1:0] q_nxt;

    always_comb begin
        a_mag   = (signed_div && opa[DW-1]) ? -opa : opa;
        b_mag   = (signed_div && opb[DW-1]) ? -opb : opb;
        rem_sh  = {rem, dvd[DW-1]};
        // Extra headroom bit so the borrow is the sign of the trial difference.
        diff    = {1'b0, rem_sh} - {2'b00, dvs};
        borrow  = diff[DW+1];
        // rem < dvs always holds, so the kept remainder fits in DW bits.
        rem_nxt = borrow ? rem_sh[DW-1:0] : diff[DW-1:0];
        q_nxt   = {dvd[DW-2:0], ~borrow};
    end

    // Gated by rst so a reset pulse releases the pipeline without waiting for an edge,
    // and by annul so a flush releases it in the same cycle.
    assign stall_req    = ~rst & ~annul &
                          (((state == IDLE) & start) | (state == BUSY) | (state == ZERO));
    assign result_valid = ~rst & ~annul & (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        count  <= '0;
                        sign_q <= signed_div & (opa[DW-1] ^ opb[DW-1]);
                        sign_r <= signed_div & opa[DW-1];
                        state  <= (opb == '0) ? ZERO : BUSY;
                    end
                end
                ZERO: begin
                    // Quotient is forced to all ones; restoring the dividend sign
                    // gives back the raw dividend as the remainder.
                    quotient  <= '1;
                    remainder <= sign_r ? -dvd : dvd;
                    div_zero  <= 1'b1;
                    state     <= DONE;
                end
                BUSY: begin
                    rem   <= rem_nxt;
                    dvd   <= q_nxt;
                    count <= count + CW'(1);
                    if (count == CW'(DW-1)) begin
                        // Signs are applied as the final step lands, so the
                        // outputs are already valid throughout DONE.
                        quotient  <= sign_q ? -q_nxt : q_nxt;
                        remainder <= sign_r ? -rem_nxt : rem_nxt;
                        div_zero  <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a scoreboard queue of expected results.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int vectors;
    int miscompares;
    logic [64:0] sb[$];
    logic [64:0] last;

    div_unit #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_zero     (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {div_zero, quotient, remainder} built from operand magnitudes.
    function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        ma = (s && a[31]) ? (32'd0 - a) : a;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] ^ b[31])) q = 32'd0 - q;
        if (s && a[31])           r = 32'd0 - r;
        return {1'b0, q, r};
    endfunction

    // Issue one divide at the next cycle, check stall_req every cycle until the
    // result pulse, then check latency and the popped scoreboard entry.
    // With keep=1, start stays high and the operands switch to the n* values
    // so the next call's divide is already being requested while this one runs.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic keep, input logic ns, input logic [31:0] na,
                          input logic [31:0] nb);
        int cyc;
        int lat;
        logic got;
        logic [64:0] e;
        @(posedge clk); #1;
        start = 1'b1; signed_div = s; opa = a; opb = b;
        sb.push_back(model(s, a, b));
        lat = (b == 32'd0) ? 2 : 33;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                chk("stall_in_done", {63'd0, stall_req}, 64'd0);
            end else begin
                if (stall_req !== 1'b1) chk("stall_busy", {63'd0, stall_req}, 64'd1);
                @(posedge clk); #1;
                cyc++;
                if (keep) begin
                    signed_div = ns; opa = na; opb = nb;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("latency", 64'(cyc), 64'(lat));
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            last = e;
            chk("quotient",  {32'd0, quotient},  {32'd0, e[63:32]});
            chk("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
            chk("div_zero",  {63'd0, div_zero},  {63'd0, e[64]});
        end
    endtask

    initial begin
        logic saw;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;
        #12;
        chk("rst_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_valid", {63'd0, result_valid}, 64'd0);
        chk("rst_outs",  {quotient, remainder}, 64'd0);
        chk("rst_dz",    {63'd0, div_zero}, 64'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_div(1'b1, 32'd77, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Annul at BUSY cycle 10: no pulse, outputs keep the previous result.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        annul = 1'b1;
        #1;
        chk("annul_stall", {63'd0, stall_req}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0;
        saw = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (result_valid || stall_req) saw = 1'b1;
        end
        chk("annul_no_pulse", {63'd0, saw}, 64'd0);
        chk("annul_hold", {quotient, remainder}, last[63:0]);
        do_div(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);

        // Back-to-back: start held high through BUSY/DONE of the first divide.
        do_div(1'b0, 32'd1234567, 32'd89, 1'b1, 1'b1, 32'hFFFF_FC00, 32'd10);
        do_div(1'b1, 32'hFFFF_FC00, 32'd10, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            do_div(1'(i & 1), ra, rb, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        // Async reset mid-BUSY, checked before any clock edge.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opa = 32'd500; opb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", {63'd0, stall_req}, 64'd0);
        chk("rst_mid_outs",  {quotient, remainder}, 64'd0);
        chk("rst_mid_dz",    {63'd0, div_zero}, 64'd0);
        #1;
        rst = 1'b0;
        do_div(1'b0, 32'd123, 32'd10, 1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
